// File: rtl/hilo_div_unit_pkg.sv
// Shared types and constants for the HI/LO iterative divider.
package hilo_div_unit_pkg;

   localparam int WIDTH = 32;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Unsigned magnitude of an operand; 0x80000000 maps to itself.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                  input logic is_signed);
      return (is_signed && value[WIDTH-1]) ? -value : value;
   endfunction

endpackage

// File: rtl/hilo_div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface hilo_div_unit_if
   import hilo_div_unit_pkg::*;
   ();

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             hi_wea;
   logic [WIDTH-1:0] hi_wdata;
   logic             lo_wea;
   logic [WIDTH-1:0] lo_wdata;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, hi_wea, hi_wdata, lo_wea, lo_wdata
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, hi_wea, hi_wdata, lo_wea, lo_wdata
   );

endinterface

// File: rtl/hilo_div_unit_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo}, trial-subtract, select.
module hilo_div_unit_div_step
   import hilo_div_unit_pkg::*;
   (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
   );

   logic [WIDTH:0] rem_shifted;
   logic [WIDTH:0] trial;

   // Bit WIDTH of the 33-bit trial is its sign: rem stays below the divisor
   // (or below 2^31 on the divide-by-zero path), so a valid difference never
   // reaches bit WIDTH and a negative one always sets it.
   always_comb begin
      rem_shifted = {rem_i, quo_i[WIDTH-1]};
      trial       = rem_shifted - {1'b0, divisor_i};
      if (!trial[WIDTH]) begin
         rem_o = trial[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative DIV/DIVU unit: remainder to HI, quotient to LO, one write pulse per op.
module hilo_div_unit
   import hilo_div_unit_pkg::*;
   (
   input  logic                  clk,
   input  logic                  rst,
   hilo_div_unit_if.slave        bus
   );

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic             wr_en;

   hilo_div_unit_div_step u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (rem_d),
      .quo_o     (quo_d)
   );

   // Control FSM with operand capture, iteration and registered busy/done flags.
   // NOTE: every register here is assigned with <= so all updates see the
   // values from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  rem_q     <= '0;
                  quo_q     <= magnitude(bus.dividend, bus.is_signed);
                  dvs_q     <= magnitude(bus.divisor, bus.is_signed);
                  neg_quo_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                  neg_rem_q <= bus.is_signed & bus.dividend[WIDTH-1];
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Write pulse and sign-corrected result; rst suppresses a pulse in the DONE cycle.
   // NOTE: each output gets a value on every path, so no latch can be inferred.
   always_comb begin
      wr_en        = done_q & ~rst;
      bus.busy     = busy_q;
      bus.hi_wea   = wr_en;
      bus.lo_wea   = wr_en;
      bus.hi_wdata = '0;
      bus.lo_wdata = '0;
      if (wr_en) begin
         bus.hi_wdata = neg_rem_q ? -rem_q : rem_q;
         bus.lo_wdata = neg_quo_q ? -quo_q : quo_q;
      end
   end

endmodule
